// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle of the signals exchanged between the pipeline and the hazard/stall
//   controller.
//   master : pipeline side. Drives the ID decode info, the EX multi-cycle
//            handshake, the MEM wait and the flush request. Receives the
//            control outputs.
//   slave  : hazard_ctrl side.
//   Signals:
//     id_valid, id_is_load, id_write_reg_en, id_write_reg_addr[4:0]
//                             ID instruction and its destination
//     reg_read_en_1/2, reg_addr_1/2[4:0]
//                             ID source ports
//     ex_mc_req, ex_mc_done   EX multi-cycle request (level) and completion (pulse)
//     mem_wait, flush_req     MEM bus wait and exception/eret flush request
//     stall[5:0]              stage stall vector (0=PC,1=IF,2=ID,3=EX,4=MEM,5=WB)
//     bubble_ex, flush        ID/EX NOP insert, whole-pipeline clear
//     mc_cancel, mc_timeout   multi-cycle abort pulse, sticky watchdog error
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
   logic       id_valid;
   logic       id_is_load;
   logic       id_write_reg_en;
   logic [4:0] id_write_reg_addr;
   logic       reg_read_en_1;
   logic       reg_read_en_2;
   logic [4:0] reg_addr_1;
   logic [4:0] reg_addr_2;
   logic       ex_mc_req;
   logic       ex_mc_done;
   logic       mem_wait;
   logic       flush_req;
   logic [5:0] stall;
   logic       bubble_ex;
   logic       flush;
   logic       mc_cancel;
   logic       mc_timeout;

   modport master (
      output id_valid, id_is_load, id_write_reg_en, id_write_reg_addr,
             reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
             ex_mc_req, ex_mc_done, mem_wait, flush_req,
      input  stall, bubble_ex, flush, mc_cancel, mc_timeout
   );

   modport slave (
      input  id_valid, id_is_load, id_write_reg_en, id_write_reg_addr,
             reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
             ex_mc_req, ex_mc_done, mem_wait, flush_req,
      output stall, bubble_ex, flush, mc_cancel, mc_timeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for the five-stage MIPS pipeline. Tracks the
//   destination of a load sitting in EX (one-entry scoreboard), detects
//   load-use hazards in ID, sequences multi-cycle EX operations (DIV/DIVU)
//   with a watchdog, and merges these with MEM waits and flush requests into
//   the stall vector, the ID/EX bubble and the flush.
//   Parameters:
//     MC_MAX_CYCLES  watchdog limit for one multi-cycle operation
//     CNT_W          watchdog counter width, 2**CNT_W > MC_MAX_CYCLES
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     hz             hazard_ctrl_if.slave (see the interface file)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MC_MAX_CYCLES = 40,
   parameter int CNT_W         = 6
) (
   input  logic           clk,
   input  logic           rst,
   hazard_ctrl_if.slave   hz
);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_ex_valid_q, ld_ex_valid_d;
   logic [4:0]       ld_ex_addr_q, ld_ex_addr_d;
   logic             mc_timeout_q, mc_timeout_d;

   logic       mc_busy;
   logic       mc_stall;
   logic       lu_haz;
   logic       wd_hit;
   logic       flush_cancel;
   logic [5:0] stall_c;
   logic       bubble_c;
   logic       flush_c;
   logic       cancel_c;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   assign mc_busy  = (state_q == MC_BUSY);
   // The request cycle itself already stalls, before the FSM has moved.
   assign mc_stall = mc_busy | hz.ex_mc_req;

   // A tracked load to $0 never produces a hazard.
   assign lu_haz = ld_ex_valid_q && (ld_ex_addr_q != 5'd0) &&
                   ((hz.reg_read_en_1 && (hz.reg_addr_1 == ld_ex_addr_q)) ||
                    (hz.reg_read_en_2 && (hz.reg_addr_2 == ld_ex_addr_q)));

   // Watchdog: the counter holds the number of cycles elapsed since the
   // request cycle, so it reads MC_MAX_CYCLES-1 in the last allowed cycle.
   assign wd_hit = mc_busy && !hz.ex_mc_done && (cnt_q == CNT_LAST);

   // A flush aborts an operation in flight or just being requested, unless
   // the operation completes in the same cycle.
   assign flush_cancel = hz.flush_req &&
                         (mc_busy ? !hz.ex_mc_done : hz.ex_mc_req);

   // ------------------------------------------------------------------
   // Combinational outputs, fixed priority
   // ------------------------------------------------------------------
   always_comb begin
      stall_c  = 6'b000000;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      cancel_c = 1'b0;
      if (!rst) begin
         cancel_c = flush_cancel | (wd_hit & ~hz.flush_req);
         if (hz.flush_req) begin
            flush_c = 1'b1;
         end else if (hz.mem_wait) begin
            stall_c = 6'b011111;
         end else if (mc_stall) begin
            stall_c = 6'b001111;
         end else if (lu_haz) begin
            stall_c  = 6'b000111;
            bubble_c = 1'b1;
         end
      end
   end

   assign hz.stall      = stall_c;
   assign hz.bubble_ex  = bubble_c;
   assign hz.flush      = flush_c;
   assign hz.mc_cancel  = cancel_c;
   assign hz.mc_timeout = mc_timeout_q;

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mc_timeout_d  = mc_timeout_q;
      ld_ex_valid_d = ld_ex_valid_q;
      ld_ex_addr_d  = ld_ex_addr_q;

      // Multi-cycle FSM and watchdog counter
      if (hz.flush_req) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hz.ex_mc_req) begin
                  state_d = MC_BUSY;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
            MC_BUSY: begin
               if (hz.ex_mc_done) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d      = IDLE;
                  cnt_d        = '0;
                  mc_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Load scoreboard follows the ID/EX register: hold while EX is
      // stalled so a masked hazard is re-evaluated once the stall clears.
      if (hz.flush_req) begin
         ld_ex_valid_d = 1'b0;
      end else if (stall_c[3]) begin
         ld_ex_valid_d = ld_ex_valid_q;
      end else if (bubble_c) begin
         ld_ex_valid_d = 1'b0;
      end else if (!stall_c[2]) begin
         ld_ex_valid_d = hz.id_valid & hz.id_is_load & hz.id_write_reg_en;
         ld_ex_addr_d  = hz.id_write_reg_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         ld_ex_valid_q <= 1'b0;
         ld_ex_addr_q  <= 5'd0;
         mc_timeout_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ld_ex_valid_q <= ld_ex_valid_d;
         ld_ex_addr_q  <= ld_ex_addr_d;
         mc_timeout_q  <= mc_timeout_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Each task drives one scenario cycle
//   by cycle, pushes the expected outputs of that cycle to a queue, and pops
//   and compares them at the falling edge. Expected vector layout:
//   {stall[5:0], bubble_ex, flush, mc_cancel, mc_timeout}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   hazard_ctrl_if hz();

   hazard_ctrl #(.MC_MAX_CYCLES(40), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_total = 0;
   int         n_pass  = 0;
   logic       exp_to  = 1'b0;
   logic [9:0] exp_q[$];
   logic [9:0] e;
   logic [9:0] obs;

   function automatic logic [9:0] mk(input logic [5:0] s, input logic b,
                                     input logic f, input logic c);
      return {s, b, f, c, exp_to};
   endfunction

   task automatic drive(input logic v, input logic ld, input logic we,
                        input logic [4:0] wa,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2,
                        input logic req, input logic done,
                        input logic mw, input logic fl);
      hz.id_valid          = v;
      hz.id_is_load        = ld;
      hz.id_write_reg_en   = we;
      hz.id_write_reg_addr = wa;
      hz.reg_read_en_1     = e1;
      hz.reg_addr_1        = a1;
      hz.reg_read_en_2     = e2;
      hz.reg_addr_2        = a2;
      hz.ex_mc_req         = req;
      hz.ex_mc_done        = done;
      hz.mem_wait          = mw;
      hz.flush_req         = fl;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1, 1, 1, 5'd1, 1, 5'd1, 1, 5'd1, 1, 0, 1, 1);
      @(posedge clk); #1;
      exp_to = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            rst = 1'b0;
            drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
         end
         exp_q.push_back(mk(6'b000000, 0, 0, 0));
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL reset cyc%0d got=%b exp=%b", i, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   // p=1: port 1 reads $2, p=2: port 2 reads $7, p=3: disabled port matches $4
   task automatic test_load_use();
      logic [4:0] a;
      for (int p = 1; p <= 3; p++) begin
         a = (p == 1) ? 5'd2 : (p == 2) ? 5'd7 : 5'd4;
         for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
               drive(1, 1, 1, a, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
               exp_q.push_back(mk(6'b000000, 0, 0, 0));
            end else begin
               drive(1, 0, 1, 5'd9, (p == 1), (p == 2) ? 5'd0 : a,
                     (p == 2), (p == 2) ? a : 5'd0, 0, 0, 0, 0);
               if (c == 1 && p != 3) exp_q.push_back(mk(6'b000111, 1, 0, 0));
               else                  exp_q.push_back(mk(6'b000000, 0, 0, 0));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
            n_total++;
            if (obs !== e) $display("FAIL load_use p%0d cyc%0d got=%b exp=%b", p, c, obs, e);
            else n_pass++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_load_zero();
      for (int c = 0; c < 2; c++) begin
         if (c == 0) drive(1, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
         else        drive(1, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
         exp_q.push_back(mk(6'b000000, 0, 0, 0));
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL load_zero cyc%0d got=%b exp=%b", c, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   // DIV finishing in its 34th cycle
   task automatic test_mc_done();
      for (int i = 1; i <= 35; i++) begin
         drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, (i <= 34), (i == 34), 0, 0);
         exp_q.push_back(mk((i <= 34) ? 6'b001111 : 6'b000000, 0, 0, 0));
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL mc_done cyc%0d got=%b exp=%b", i, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait_lu();
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin
            drive(1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
            exp_q.push_back(mk(6'b000000, 0, 0, 0));
         end else begin
            drive(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0, (c <= 3), 0);
            if (c <= 3)      exp_q.push_back(mk(6'b011111, 0, 0, 0));
            else if (c == 4) exp_q.push_back(mk(6'b000111, 1, 0, 0));
            else             exp_q.push_back(mk(6'b000000, 0, 0, 0));
         end
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL mem_wait_lu cyc%0d got=%b exp=%b", c, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   // done never comes: cancel in cycle 40, stall released in 41, sticky error
   task automatic test_watchdog();
      for (int i = 1; i <= 42; i++) begin
         drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, (i <= 40), 0, 0, 0);
         if (i == 41) exp_to = 1'b1;
         exp_q.push_back(mk((i <= 40) ? 6'b001111 : 6'b000000, 0, 0, (i == 40)));
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL watchdog cyc%0d got=%b exp=%b", i, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c <= 10; c++) begin
         case (c)
            0, 1, 2, 3: begin
               drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
               exp_q.push_back(mk(6'b001111, 0, 0, 0));
            end
            4: begin   // flush mid-operation with a load sitting in ID
               drive(1, 1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
               exp_q.push_back(mk(6'b000000, 0, 1, 1));
            end
            5: begin   // load was not tracked, FSM back in IDLE
               drive(1, 0, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 0, 0, 0);
               exp_q.push_back(mk(6'b000000, 0, 0, 0));
            end
            6: begin   // flush while a request is just being raised
               drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
               exp_q.push_back(mk(6'b000000, 0, 1, 1));
            end
            8: begin
               drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
               exp_q.push_back(mk(6'b001111, 0, 0, 0));
            end
            9: begin   // flush and done together: no cancel
               drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 1);
               exp_q.push_back(mk(6'b000000, 0, 1, 0));
            end
            default: begin
               drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
               exp_q.push_back(mk(6'b000000, 0, 0, 0));
            end
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL flush cyc%0d got=%b exp=%b", c, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rst_mid();
      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
            exp_q.push_back(mk(6'b001111, 0, 0, 0));
         end else if (c == 3) begin
            rst = 1'b1;
            drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 1, 0);
            exp_q.push_back(mk(6'b000000, 0, 0, 0));
         end else begin
            rst = 1'b0;
            exp_to = 1'b0;
            drive(1, 0, 0, 5'd0, 1, 5'd3, 1, 5'd5, 0, 0, 0, 0);
            exp_q.push_back(mk(6'b000000, 0, 0, 0));
         end
         @(negedge clk);
         e = exp_q.pop_front();
         obs = {hz.stall, hz.bubble_ex, hz.flush, hz.mc_cancel, hz.mc_timeout};
         n_total++;
         if (obs !== e) $display("FAIL rst_mid cyc%0d got=%b exp=%b", c, obs, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_load_zero();
      test_mc_done();
      test_mem_wait_lu();
      test_watchdog();
      test_flush();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
